// File: rtl/afe_sync_gen.sv
// afe_sync_gen: align/sync pulse-train generator for the AFE synchronisation path.
// After start and afe_ready it issues one 2-cycle align pulse, waits ALIGN_GAP
// low cycles, then issues n_sync 2-cycle sync pulses spaced prd cycles apart
// (n_sync = 0 runs until abort or loss of afe_ready). ALIGN_GAP must be >= 2.
`timescale 1ns/1ps
module afe_sync_gen #(
  parameter int PRD_W     = 32,
  parameter int CNT_W     = 16,
  parameter int ALIGN_GAP = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_afe_ready,
  input  logic [PRD_W-1:0] i_prd,
  input  logic [CNT_W-1:0] i_n_sync,
  output logic             o_align_x2,
  output logic             o_sync_x2,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_sync_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ALIGN,
    S_GAP,
    S_SYNC,
    S_DONE
  } state_t;

  localparam logic [PRD_W-1:0] GAP_LAST = PRD_W'(ALIGN_GAP - 1);
  localparam logic [PRD_W-1:0] PRD_MIN  = PRD_W'(4);

  state_t           r_state;
  logic [PRD_W-1:0] r_prd;
  logic [CNT_W-1:0] r_n_sync;
  logic [PRD_W-1:0] r_cnt;       // shared align / gap / period cycle counter
  logic             r_align;
  logic             r_sync;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_sync_cnt;

  state_t           w_state_nxt;
  logic [PRD_W-1:0] w_cnt_nxt;
  logic             w_align_nxt;
  logic             w_sync_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic [CNT_W-1:0] w_sync_cnt_nxt;
  logic             w_latch;
  logic             w_busy;
  logic             w_armed;     // states in which afe_ready must stay high
  logic             w_last_pulse;
  logic [PRD_W-1:0] w_prd_clamped;

  assign w_busy        = (r_state == S_WAIT_RDY) || (r_state == S_ALIGN) ||
                         (r_state == S_GAP)      || (r_state == S_SYNC);
  assign w_armed       = (r_state == S_ALIGN) || (r_state == S_GAP) ||
                         (r_state == S_SYNC);
  // A period below 4 would leave fewer than 2 low cycles between pulses.
  assign w_prd_clamped = (i_prd < PRD_MIN) ? PRD_MIN : i_prd;
  assign w_last_pulse  = (r_n_sync != '0) && (r_sync_cnt == r_n_sync);

  // Next-state and next-output logic; pulse outputs default low every cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_align_nxt    = 1'b0;
    w_sync_nxt     = 1'b0;
    w_done_nxt     = r_done;
    w_err_nxt      = r_err;
    w_sync_cnt_nxt = r_sync_cnt;
    w_latch        = 1'b0;

    if (w_busy && i_abort) begin
      w_state_nxt = S_IDLE;
    end else if (w_armed && !i_afe_ready) begin
      w_state_nxt = S_IDLE;
      w_err_nxt   = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          // start together with abort is dropped
          if (i_start && !i_abort) begin
            w_state_nxt    = S_WAIT_RDY;
            w_latch        = 1'b1;
            w_done_nxt     = 1'b0;
            w_err_nxt      = 1'b0;
            w_sync_cnt_nxt = '0;
            w_cnt_nxt      = '0;
          end
        end
        S_WAIT_RDY: begin
          if (i_afe_ready) begin
            w_state_nxt = S_ALIGN;
            w_align_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end
        end
        S_ALIGN: begin
          if (r_cnt == '0) begin
            w_align_nxt = 1'b1;
            w_cnt_nxt   = PRD_W'(1);
          end else begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = '0;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_state_nxt    = S_SYNC;
            w_sync_nxt     = 1'b1;
            w_cnt_nxt      = '0;
            w_sync_cnt_nxt = r_sync_cnt + 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_SYNC: begin
          if ((r_cnt == PRD_W'(1)) && w_last_pulse) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else if (r_cnt == r_prd - 1'b1) begin
            w_sync_nxt     = 1'b1;
            w_cnt_nxt      = '0;
            w_sync_cnt_nxt = r_sync_cnt + 1'b1;
          end else begin
            w_sync_nxt = (r_cnt == '0);
            w_cnt_nxt  = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_prd      <= '0;
      r_n_sync   <= '0;
      r_cnt      <= '0;
      r_align    <= 1'b0;
      r_sync     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_sync_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_align    <= w_align_nxt;
      r_sync     <= w_sync_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_sync_cnt <= w_sync_cnt_nxt;
      if (w_latch) begin
        r_prd    <= w_prd_clamped;
        r_n_sync <= i_n_sync;
      end
    end
  end

  assign o_align_x2 = r_align;
  assign o_sync_x2  = r_sync;
  assign o_busy     = w_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_sync_cnt = r_sync_cnt;

endmodule
